// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwr_seq.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__pwr_seq
//
// Staggered rail-segment enable sequencer. Turns on NSEG switched-rail
// segments one at a time (bit 0 first), spaced by DWELL+1 cycles, raises READY
// once all are on, and powers them down in reverse order when EN drops.
// SEG_EN is always a thermometer code.
//
// Parameters:
//   NSEG     number of rail segments (2..16)
//   DWELL_W  width of the DWELL input / dwell down-counter
//
// Ports:
//   CLK     rising-edge clock
//   RN      asynchronous active-low reset (crash-off: all enables drop at once)
//   EN      rail request level (1 = on, 0 = off)
//   DWELL   extra cycles between segment steps, sampled at every counter load
//   SEG_EN  segment enables, bit 0 first on / last off
//   READY   all segments on and settled
//   BUSY    sequencing in progress (UP or DOWN)
//   ISO     isolation clamp, only when GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
//           is defined (reset value 1, low only while settled ON)
//
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__pwr_seq #(
    parameter int NSEG    = 4,
    parameter int DWELL_W = 4
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               EN,
    input  logic [DWELL_W-1:0] DWELL,
    output logic [NSEG-1:0]    SEG_EN,
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
    output logic               ISO,
`endif
    output logic               READY,
    output logic               BUSY
);

    localparam int IW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [DWELL_W-1:0] cnt;
    logic [IW-1:0]      idx_inc;
    logic [IW-1:0]      idx_dec;

    always_comb begin
        idx_inc = idx + 1'b1;
        idx_dec = idx - 1'b1;
    end

    // In UP/ON, idx points at the highest set segment. In DOWN, idx points at
    // the segment most recently cleared, so an abort re-sets SEG_EN[idx] and
    // the next down-step clears SEG_EN[idx-1].
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= S_OFF;
            SEG_EN <= '0;
            READY  <= 1'b0;
            BUSY   <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
            ISO    <= 1'b1;
`endif
        end else begin
            case (state)
                S_OFF: begin
                    if (EN) begin
                        state     <= S_UP;
                        BUSY      <= 1'b1;
                        SEG_EN[0] <= 1'b1;
                        idx       <= '0;
                        cnt       <= DWELL;
                    end
                end

                S_UP: begin
                    if (!EN) begin
                        SEG_EN[idx] <= 1'b0;
                        cnt         <= DWELL;
                        // Dropping the last segment lands directly in OFF.
                        if (idx == '0) begin
                            state <= S_OFF;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= S_DOWN;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (idx != LAST) begin
                        idx             <= idx_inc;
                        SEG_EN[idx_inc] <= 1'b1;
                        cnt             <= DWELL;
                    end else begin
                        state <= S_ON;
                        BUSY  <= 1'b0;
                        READY <= 1'b1;
                    end
                end

                S_ON: begin
                    if (!EN) begin
                        state       <= S_DOWN;
                        BUSY        <= 1'b1;
                        READY       <= 1'b0;
                        SEG_EN[idx] <= 1'b0;
                        cnt         <= DWELL;
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
                        ISO         <= 1'b1;
`endif
                    end else begin
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
                        // Release the clamp one edge after READY rose.
                        ISO <= 1'b0;
`endif
                    end
                end

                S_DOWN: begin
                    if (EN) begin
                        state       <= S_UP;
                        SEG_EN[idx] <= 1'b1;
                        cnt         <= DWELL;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        idx             <= idx_dec;
                        SEG_EN[idx_dec] <= 1'b0;
                        cnt             <= DWELL;
                        if (idx_dec == '0) begin
                            state <= S_OFF;
                            BUSY  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_OFF;
                    BUSY  <= 1'b0;
                    READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__pwr_seq
//
// Directed bench for the rail-segment sequencer (NSEG=4, DWELL_W=4). Expected
// {SEG_EN, READY, BUSY} values are derived from the edge-timing formulas and
// queued before each clock edge; they are popped and compared 1 time unit
// after the edge. Define GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN to also
// check the ISO clamp.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__pwr_seq;

    localparam int NSEG    = 4;
    localparam int DWELL_W = 4;

    logic               CLK;
    logic               RN;
    logic               EN;
    logic [DWELL_W-1:0] DWELL;
    logic [NSEG-1:0]    SEG_EN;
    logic               READY;
    logic               BUSY;
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
    logic               ISO;
`endif

    gf180mcu_fd_sc_mcu9t5v0__pwr_seq #(
        .NSEG    (NSEG),
        .DWELL_W (DWELL_W)
    ) dut (
        .CLK    (CLK),
        .RN     (RN),
        .EN     (EN),
        .DWELL  (DWELL),
        .SEG_EN (SEG_EN),
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
        .ISO    (ISO),
`endif
        .READY  (READY),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NSEG-1:0] seg;
        logic            ready;
        logic            busy;
    } exp_t;

    exp_t  sb[$];
    int    total  = 0;
    int    passed = 0;

    function automatic logic [NSEG-1:0] therm(input int n);
        logic [NSEG:0] t;
        t = (NSEG+1)'((1 << n) - 1);
        return t[NSEG-1:0];
    endfunction

    function automatic exp_t mk(input int ones, input logic r, input logic b);
        exp_t e;
        e.seg   = therm(ones);
        e.ready = r;
        e.busy  = b;
        return e;
    endfunction

    // Pop the oldest expectation and compare against the live outputs.
    task automatic check(input string tag);
        exp_t e;
        exp_t o;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            o = '{seg: SEG_EN, ready: READY, busy: BUSY};
            total++;
            assert (o === e) passed++;
            else $error("FAIL %s: seg/ready/busy got %b/%b/%b want %b/%b/%b",
                        tag, o.seg, o.ready, o.busy, e.seg, e.ready, e.busy);
        end
    endtask

    // Queue the expectation for the next edge, take the edge, compare.
    task automatic cyc(input exp_t e, input string tag);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check(tag);
    endtask

`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
    task automatic check_iso(input logic want, input string tag);
        total++;
        assert (ISO === want) passed++;
        else $error("FAIL %s: iso got %b want %b", tag, ISO, want);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RN    = 1'b0;
        EN    = 1'b0;
        DWELL = '0;
        #2;
        sb.push_back(mk(0, 1'b0, 1'b0));
        check("reset");
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
        check_iso(1'b1, "iso_reset");
`endif
        @(posedge CLK);
        #1;
        RN = 1'b1;
        cyc(mk(0, 1'b0, 1'b0), "idle_off");

        // Power-up, DWELL=2: segment k at E0+3k, READY at E0+12.
        DWELL = 4'd2;
        EN    = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            int ones;
            ones = (k / 3 + 1 > NSEG) ? NSEG : k / 3 + 1;
            cyc(mk(ones, k >= 12, k < 12), $sformatf("up_d2_k%0d", k));
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
            if (k == 11) check_iso(1'b1, "iso_before_ready");
`endif
        end
        cyc(mk(4, 1'b1, 1'b0), "on_hold");
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
        check_iso(1'b0, "iso_after_ready");
`endif

        // Power-down, DWELL=1: segment 3-j off at F0+2j, OFF at F0+6.
        DWELL = 4'd1;
        EN    = 1'b0;
        for (int m = 0; m <= 6; m++) begin
            cyc(mk(3 - m / 2, 1'b0, m < 6), $sformatf("down_d1_m%0d", m));
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
            if (m == 0) check_iso(1'b1, "iso_enter_down");
`endif
        end
        cyc(mk(0, 1'b0, 1'b0), "off_hold");

        // DWELL=0: one segment per edge, READY 4 edges after E0.
        DWELL = 4'd0;
        EN    = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            cyc(mk((k + 1 > NSEG) ? NSEG : k + 1, k >= 4, k < 4),
                $sformatf("up_d0_k%0d", k));
        end

        // Abort: DWELL=3 (takes effect at the next load), fall to 0011 then
        // re-request; back to 0111, 1111 four edges later, READY four more.
        DWELL = 4'd3;
        EN    = 1'b0;
        for (int m = 0; m <= 4; m++) begin
            cyc(mk((m < 4) ? 3 : 2, 1'b0, 1'b1), $sformatf("abort_down_m%0d", m));
        end
        EN = 1'b1;
        for (int a = 0; a <= 8; a++) begin
            cyc(mk((a < 4) ? 3 : 4, a >= 8, a < 8), $sformatf("abort_up_a%0d", a));
        end
        cyc(mk(4, 1'b1, 1'b0), "abort_on_hold");

        // One-cycle EN glitch in ON with DWELL=0.
        DWELL = 4'd0;
        EN    = 1'b0;
        cyc(mk(3, 1'b0, 1'b1), "glitch_drop");
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
        check_iso(1'b1, "iso_glitch");
`endif
        EN = 1'b1;
        cyc(mk(4, 1'b0, 1'b1), "glitch_resume");
        cyc(mk(4, 1'b1, 1'b0), "glitch_ready");
        cyc(mk(4, 1'b1, 1'b0), "glitch_hold");
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
        check_iso(1'b0, "iso_glitch_release");
`endif

        // Fast shutdown to OFF, then reset pulse mid-UP.
        EN = 1'b0;
        for (int m = 0; m <= 3; m++) begin
            cyc(mk(3 - m, 1'b0, m < 3), $sformatf("fast_down_m%0d", m));
        end
        DWELL = 4'd2;
        EN    = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            cyc(mk(k / 3 + 1, 1'b0, 1'b1), $sformatf("pre_rst_k%0d", k));
        end
        #2;
        RN = 1'b0;
        #1;
        sb.push_back(mk(0, 1'b0, 1'b0));
        check("async_reset");
`ifdef GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN
        check_iso(1'b1, "iso_async_reset");
`endif
        cyc(mk(0, 1'b0, 1'b0), "reset_held");
        RN = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            cyc(mk(k / 3 + 1, 1'b0, 1'b1), $sformatf("restart_k%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__pwr_seq.md
# gf180mcu_fd_sc_mcu9t5v0__pwr_seq

Staggered rail-segment enable sequencer for the 9-track 5 V library. It drives the enables of NSEG power-switch/filler-tap segments on a switched VDD rail one at a time, so inrush is spread over a programmable dwell interval. It raises READY once every segment is on, and powers segments down in reverse order. It sits between the always-on control logic and the switched rail that the fill/tap rows feed.

## Interface
Parameters:
- NSEG, 4, number of rail segments (2..16)
- DWELL_W, 4, width of the dwell-count input

Ports (single clock CLK; reset RN is asynchronous, active-low):
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- EN  input  1  rail request level: 1 = rail on, 0 = rail off
- DWELL  input  DWELL_W  extra cycles between segment steps; sampled at every counter load
- SEG_EN  output  NSEG  segment enables, bit 0 first on / last off
- READY  output  1  all segments on and settled
- BUSY  output  1  sequencing in progress (state UP or DOWN)

## Operation
- States: OFF, UP, ON, DOWN. Internal: idx (segment pointer), cnt (DWELL_W-bit down-counter).
- OFF, EN=1: go to UP. Set SEG_EN[0]=1, idx=0, cnt=DWELL.
- UP, EN=1, cnt≠0: decrement cnt.
- UP, EN=1, cnt=0, idx<NSEG-1: increment idx, set SEG_EN[idx], reload cnt=DWELL.
- UP, EN=1, cnt=0, idx=NSEG-1: go to ON; READY=1.
- ON, EN=1: hold.
- ON or UP, EN=0: go to DOWN. READY=0. Clear the highest set bit SEG_EN[idx] on the same edge, then cnt=DWELL.
- DOWN, EN=0, cnt≠0: decrement cnt.
- DOWN, EN=0, cnt=0, idx>0: decrement idx, clear SEG_EN[idx], reload cnt.
- Clearing of SEG_EN[0] moves the block to OFF in the same edge.
- DOWN, EN=1 (abort): go to UP. Set the next bit above the highest still-set bit, or bit idx if it is already clear. Reload cnt=DWELL.
- SEG_EN is always a thermometer code (contiguous ones from bit 0). The ordering of a step never skips or reorders segments.
- DWELL=0 gives one segment step per cycle.
- DWELL changes take effect only at the next load.

## Timing
- Reset (RN=0, asynchronous): state=OFF, SEG_EN=0, READY=0, BUSY=0, idx=0, cnt=0. Outputs clear immediately, without waiting for CLK.
- Reset release: synchronous to CLK; the first active edge is the one after RN rises.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let E0 be the first edge with EN=1 sampled in OFF, and D the value of DWELL.
  - Segment k turns on at edge E0 + k·(D+1).
  - READY rises at edge E0 + NSEG·(D+1).
- Power-down from ON starts at edge F0, the first edge with EN=0.
  - Segment NSEG-1-j turns off at F0 + j·(D+1).
  - The block reaches OFF at F0 + (NSEG-1)·(D+1).
- BUSY is high exactly while the state is UP or DOWN.
- A one-cycle EN glitch in ON drops READY and one segment, then resumes UP.
- Reset asserted mid-sequence: all enables drop at once. This is the deliberate crash-off path.

## Configuration
- Macro GF180MCU_FD_SC_MCU9T5V0__PWR_SEQ_ISO_EN defined:
  - Adds an output port ISO (1 bit, registered, reset value 1). ISO is the isolation clamp for downstream logic.
  - ISO falls on the edge after READY rises.
  - ISO rises on the same edge that entering DOWN clears READY, before any further segment change.
- Macro not defined: there is no ISO port and no ISO logic. All other behaviour is identical.

## Test plan
- NSEG=4, DWELL=2, EN rises at E0 -> SEG_EN = 0001 @E0, 0011 @E0+3, 0111 @E0+6, 1111 @E0+9; READY=1 @E0+12; BUSY high from E0 to E0+11.
- From ON, DWELL=1, EN falls at F0 -> SEG_EN = 0111 @F0, 0011 @F0+2, 0001 @F0+4, 0000 @F0+6 and state OFF; READY=0 @F0.
- DWELL=0 -> one segment per cycle; READY 4 edges after E0.
- Abort: DWELL=3, EN low when SEG_EN=0111 in DOWN -> SEG_EN goes back to 0111, then 1111 4 edges later, then READY 4 edges after that.
- RN pulsed low mid-UP (SEG_EN=0011) -> SEG_EN=0, READY=0 and BUSY=0 with no clock edge. After release with EN=1, the sequence restarts from 0001.
- With ISO_EN defined: ISO=1 out of reset, 0 one edge after READY rises, 1 on the edge EN=0 is sampled in ON.
